wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline write-back (WB stage, highest priority) and a long-latency execution unit (multiply/divide) that returns results out of the pipeline's timing. Colliding long-latency results are held in a small in-order FIFO and drained on cycles when the WB stage does not write. The block also flags pending destination registers so the issue stage can stall on RAW/WAW hazards against buffered results. It sits between the MEM/WB pipeline register, the long-latency unit and the ID-stage register file.

## Interface

- DATA_WIDTH, 32, register data width (matches `REG_DATA_WIDTH`)
- ADDR_WIDTH, 5, register address width (matches `REG_ADDR_WIDTH`)
- DEPTH, 2, pending-result FIFO entries (power of two, ≥2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  WB stage writes a register this cycle (RegWrite from MEM/WB)
- wb_rd  in  ADDR_WIDTH  WB destination register
- wb_data  in  DATA_WIDTH  WB write-back value
- lu_valid  in  1  long-latency unit offers a result
- lu_rd  in  ADDR_WIDTH  long-latency destination register
- lu_data  in  DATA_WIDTH  long-latency result
- lu_ready  out  1  arbiter accepts the offered result this cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- q_rs1, q_rs2, q_rd  in  ADDR_WIDTH each  issuing instruction's sources and destination
- q_stall  out  1  any nonzero q_* matches a valid FIFO entry's rd
- pend_count  out  $clog2(DEPTH)+1  valid FIFO entries

## Operation

- Accept: lu_fire = lu_valid & lu_ready; lu_ready = (pend_count < DEPTH) & ~rst. No same-cycle pop credit: full FIFO deasserts lu_ready even if draining.
- WB write active: wb_act = wb_valid & (wb_rd != 0). x0 writes are idle cycles.
- Port priority, evaluated each cycle:
  1. wb_act: rf_* = WB. Any lu_fire with lu_rd != 0 is pushed.
  2. else FIFO non-empty: rf_* = FIFO head; head popped at edge. Any lu_fire with lu_rd != 0 is pushed (push and pop same edge; count unchanged).
  3. else lu_fire with lu_rd != 0: bypass, rf_* = lu_rd/lu_data, no push.
  4. else rf_we = 0; rf_waddr/rf_wdata = 0.
- lu_fire with lu_rd == 0: accepted and discarded (no write, no push).
- Ordering: long-latency results reach the register file in acceptance order; bypass occurs only with FIFO empty.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH; each entry holds rd, data.
- q_stall: combinational compare of q_rs1/q_rs2/q_rd (zero ignored) against all valid entries. Issue stage must stall on it; this prevents a younger WB write being overwritten by an older buffered result (WAW) and reads of stale values (RAW). Register-file bypass of the same-cycle write is outside this block.

## Timing

- rf_we/rf_waddr/rf_wdata, lu_ready, q_stall: combinational from current inputs and state, valid same cycle.
- Push/pop take effect at the rising edge; a pushed entry is visible in pend_count and q_stall next cycle; earliest drain is the next cycle.
- Worst-case latency from acceptance to write: unbounded while wb_act holds every cycle; otherwise position-in-FIFO cycles.
- Reset (sync, any cycle, including mid-drain): pointers and pend_count → 0, all entries invalid, contents discarded; during rst high rf_we = 0, lu_ready = 0, q_stall = 0, rf_waddr/rf_wdata = 0.
- Reset values after release: pend_count = 0, lu_ready = 1, rf_we follows inputs.

## Test plan

- Bypass: FIFO empty, wb_valid=0, lu_valid=1 rd=5 data=0xDEADBEEF -> same cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; pend_count stays 0.
- Collision: wb_valid=1 rd=3 data=0x11, lu_valid=1 rd=7 data=0x22 -> cycle 0 writes x3=0x11, pend_count=1, q_stall=1 for q_rs1=7; next idle cycle writes x7=0x22, pend_count=0.
- Fill/backpressure: wb_valid=1 rd=1 each cycle, lu offers rd=8,9,10 -> first two accepted, lu_ready=0 on third with pend_count=2; after wb_valid drops, writes x8 then x9 in order, then accepts rd=10.
- Push+pop same edge: pend_count=1 (rd=8), wb idle, lu offers rd=9 -> writes x8, pend_count stays 1, head now rd=9.
- x0 handling: wb_valid=1 rd=0 with FIFO head rd=4 -> drains x4; lu_valid=1 rd=0 -> lu_ready=1, no write, pend_count unchanged.
- Reset mid-operation: pend_count=2, assert rst one cycle -> rf_we=0, lu_ready=0 during rst; after release pend_count=0, q_stall=0, no stale write of buffered entries.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register file's single write port between the in-order WB
//   stage (highest priority) and a long-latency unit (mul/div). Long-latency
//   results that collide with a WB write are held in an in-order FIFO and
//   drained on cycles where WB does not write. Buffered destinations are
//   exposed to the issue stage through q_stall for RAW/WAW hazard stalls.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data   WB stage write request (x0 writes are idle)
//   lu_valid/lu_rd/lu_data   long-latency result offer
//   lu_ready              result accepted this cycle (FIFO not full, not in reset)
//   rf_we/rf_waddr/rf_wdata  register file write port
//   q_rs1/q_rs2/q_rd      issuing instruction's register numbers
//   q_stall               a nonzero q_* matches a buffered destination
//   pend_count            number of buffered results

module wb_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  input  logic [ADDR_WIDTH-1:0]     wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic                      lu_valid,
  input  logic [ADDR_WIDTH-1:0]     lu_rd,
  input  logic [DATA_WIDTH-1:0]     lu_data,
  output logic                      lu_ready,
  output logic                      rf_we,
  output logic [ADDR_WIDTH-1:0]     rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  input  logic [ADDR_WIDTH-1:0]     q_rs1,
  input  logic [ADDR_WIDTH-1:0]     q_rs2,
  input  logic [ADDR_WIDTH-1:0]     q_rd,
  output logic                      q_stall,
  output logic [$clog2(DEPTH):0]    pend_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] ent_rd_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_rd_d   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_d [DEPTH];

  logic wb_act;
  logic fifo_empty;
  logic lu_fire;
  logic lu_keep;
  logic push;
  logic pop;

  // Write-port arbitration and FIFO next state.
  always_comb begin
    wb_act     = wb_valid & (wb_rd != '0);
    fifo_empty = (count_q == '0);
    // No pop credit: a full FIFO refuses even on a draining cycle.
    lu_ready   = (count_q < DEPTH_C) & ~rst;
    lu_fire    = lu_valid & lu_ready;
    // Results for x0 are accepted and dropped.
    lu_keep    = lu_fire & (lu_rd != '0);

    push     = 1'b0;
    pop      = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;

    if (!rst) begin
      if (wb_act) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
        push     = lu_keep;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_waddr = ent_rd_q[rd_ptr_q];
        rf_wdata = ent_data_q[rd_ptr_q];
        pop      = 1'b1;
        push     = lu_keep;
      end else if (lu_keep) begin
        // Bypass only with the FIFO empty keeps acceptance order intact.
        rf_we    = 1'b1;
        rf_waddr = lu_rd;
        rf_wdata = lu_data;
      end
    end

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;

    if (push) begin
      ent_rd_d[wr_ptr_q]   = lu_rd;
      ent_data_d[wr_ptr_q] = lu_data;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Hazard compare against every occupied slot. A slot is occupied when its
  // distance from the read pointer (modulo DEPTH) is below the count.
  always_comb begin : stall_cmp
    logic [PTR_W-1:0] offs;
    logic             hit;
    q_stall = 1'b0;
    offs    = '0;
    hit     = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      hit  = ((q_rs1 != '0) && (q_rs1 == ent_rd_q[i])) ||
             ((q_rs2 != '0) && (q_rs2 == ent_rd_q[i])) ||
             ((q_rd  != '0) && (q_rd  == ent_rd_q[i]));
      if (({1'b0, offs} < count_q) && hit && !rst) begin
        q_stall = 1'b1;
      end
    end
  end

  assign pend_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          lu_valid;
  logic [AW-1:0] lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] q_rs1, q_rs2, q_rd;
  logic          q_stall;
  logic [1:0]    pend_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rdy;
    logic [1:0]    cnt;
    logic          stall;
  } exp_t;

  ent_t model[$];   // reference of buffered long-latency results, oldest first
  exp_t sb[$];      // expected port behaviour per driven cycle

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .q_stall(q_stall), .pend_count(pend_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (n_cmp=%0d)", n_cmp);
    $fatal(1, "timeout");
  end

  // One clock of stimulus: computes the expected port outcome from the
  // reference queue, pushes it to the scoreboard, then pops and compares it
  // against the DUT at the falling edge.
  task automatic step(input logic wv, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                      input logic lv, input logic [AW-1:0] lr, input logic [DW-1:0] ld);
    exp_t e, got;
    logic fire;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
    lu_valid = lv; lu_rd = lr; lu_data = ld;
    e.rdy   = (model.size() < DEPTH);
    e.cnt   = 2'(model.size());
    e.stall = 1'b0;
    foreach (model[k])
      if ((q_rs1 != 0 && q_rs1 == model[k].rd) || (q_rs2 != 0 && q_rs2 == model[k].rd) ||
          (q_rd != 0 && q_rd == model[k].rd))
        e.stall = 1'b1;
    fire = lv && e.rdy;
    e.we = 1'b0; e.addr = '0; e.data = '0;
    if (wv && wr != 0) begin
      e.we = 1'b1; e.addr = wr; e.data = wd;
      if (fire && lr != 0) model.push_back('{lr, ld});
    end else if (model.size() != 0) begin
      e.we = 1'b1; e.addr = model[0].rd; e.data = model[0].data;
      void'(model.pop_front());
      if (fire && lr != 0) model.push_back('{lr, ld});
    end else if (fire && lr != 0) begin
      e.we = 1'b1; e.addr = lr; e.data = ld;
    end
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: no expected entry");
    end else begin
      got = sb.pop_front();
      n_cmp++;
      if (rf_we !== got.we) begin n_err++; $display("FAIL rf_we: got %b want %b", rf_we, got.we); end
      n_cmp++;
      if (rf_waddr !== got.addr) begin n_err++; $display("FAIL rf_waddr: got %0d want %0d", rf_waddr, got.addr); end
      n_cmp++;
      if (rf_wdata !== got.data) begin n_err++; $display("FAIL rf_wdata: got %h want %h", rf_wdata, got.data); end
      n_cmp++;
      if (lu_ready !== got.rdy) begin n_err++; $display("FAIL lu_ready: got %b want %b", lu_ready, got.rdy); end
      n_cmp++;
      if (pend_count !== got.cnt) begin n_err++; $display("FAIL pend_count: got %0d want %0d", pend_count, got.cnt); end
      n_cmp++;
      if (q_stall !== got.stall) begin n_err++; $display("FAIL q_stall: got %b want %b", q_stall, got.stall); end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h66;
    q_rs1 = 5'd6; q_rs2 = '0; q_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_cmp++;
    if (lu_ready !== 1'b0) begin n_err++; $display("FAIL reset_lu_ready: got %b want 0", lu_ready); end
    n_cmp++;
    if (rf_waddr !== '0 || rf_wdata !== '0) begin
      n_err++; $display("FAIL reset_rf_bus: got %0d/%h want 0/0", rf_waddr, rf_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wb_valid = 1'b0; lu_valid = 1'b0; q_rs1 = '0;
    @(negedge clk);
    n_cmp++;
    if (pend_count !== 2'd0) begin n_err++; $display("FAIL release_pend: got %0d want 0", pend_count); end
    n_cmp++;
    if (lu_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", lu_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_bypass();
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    idle();
  endtask

  task automatic test_collision();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    q_rs1 = 5'd7;
    step(1'b0, '0, '0, 1'b0, '0, '0);   // drains x7 with stall still seen this cycle
    q_rs1 = '0;
    idle();
  endtask

  task automatic test_backpressure();
    step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd8,  32'h80);
    step(1'b1, 5'd1, 32'hA2, 1'b1, 5'd9,  32'h90);
    step(1'b1, 5'd1, 32'hA3, 1'b1, 5'd10, 32'hA0);  // full: refused
    step(1'b0, '0, '0, 1'b1, 5'd10, 32'hA0);         // drains x8, still full
    step(1'b0, '0, '0, 1'b1, 5'd10, 32'hA0);         // drains x9, accepts x10
    idle();                                          // drains x10
    idle();
  endtask

  task automatic test_push_pop();
    step(1'b1, 5'd2, 32'h20, 1'b1, 5'd8, 32'h88);
    q_rd = 5'd9; q_rs2 = 5'd8;
    step(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);          // writes x8, pushes x9
    q_rs2 = 5'd11;
    step(1'b0, '0, '0, 1'b0, '0, '0);                // stall on x9, drains it
    q_rd = '0; q_rs2 = '0;
    idle();
  endtask

  task automatic test_x0();
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h44);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd0, 32'hFF);     // x0 result dropped while wb active
    step(1'b1, 5'd0, 32'h7, 1'b0, '0, '0);           // x0 WB is idle: drains x4
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hEE);          // accepted, no write
    idle();
  endtask

  task automatic test_reset_mid();
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC0);
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD0);
    rst = 1'b1; q_rs1 = 5'd12; q_rs2 = 5'd13;
    wb_valid = 1'b0; lu_valid = 1'b1; lu_rd = 5'd14; lu_data = 32'hE0;
    @(negedge clk);
    n_cmp++;
    if (rf_we !== 1'b0) begin n_err++; $display("FAIL midrst_rf_we: got %b want 0", rf_we); end
    n_cmp++;
    if (lu_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", lu_ready); end
    n_cmp++;
    if (q_stall !== 1'b0) begin n_err++; $display("FAIL midrst_stall: got %b want 0", q_stall); end
    model.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle();   // no stale write of x12/x13; stall clear; pend 0
    q_rs1 = '0; q_rs2 = '0;
  endtask

  task automatic test_back_to_back();
    logic wv;
    for (int n = 0; n < 400; n++) begin
      // Alternate heavy-WB and light-WB phases so the FIFO fills and drains.
      wv = ((n / 25) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      q_rs1 = 5'($urandom_range(0, 7));
      q_rs2 = 5'($urandom_range(0, 7));
      q_rd  = 5'($urandom_range(0, 7));
      step(wv, 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    for (int n = 0; n < DEPTH + 2; n++) idle();
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    test_reset();
    test_bypass();
    test_collision();
    test_backpressure();
    test_push_pop();
    test_x0();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
